// File: rtl/upstream_pkg.sv
// Shared types and default widths for the upstream risk-check scheduler.
package upstream_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_CLIENT_W  = 5;
    localparam int DEF_AMOUNT_W  = 32;
    localparam int DEF_PORT_W    = $clog2(DEF_NUM_PORTS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        RESP
    } state_t;

    typedef struct packed {
        logic [DEF_PORT_W-1:0]   port;
        logic [DEF_CLIENT_W-1:0] client_id;
        logic [DEF_AMOUNT_W-1:0] amount;
        logic                    is_max;
    } txn_t;

endpackage

// File: rtl/upstream_risk_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on advance.
module rr_arbiter
    import upstream_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    localparam int PORT_W   = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PORT_W-1:0]    grant_idx,
    output logic                 grant_valid
);

    logic [PORT_W-1:0] ptr;
    logic [PORT_W:0]   cand;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, ptr} + (PORT_W+1)'(i);
            if (cand >= (PORT_W+1)'(NUM_PORTS))
                cand = cand - (PORT_W+1)'(NUM_PORTS);
            if (!grant_valid && req[cand[PORT_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PORT_W-1:0];
            end
        end
        if (grant_valid)
            grant = NUM_PORTS'(1) << grant_idx;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PORT_W'(1);
    end

endmodule

// File: rtl/upstream_risk_scheduler.sv
// Shares the upstream risk RAMs and exposure check between order-entry ports:
// round-robin grant, then read -> check -> write-back -> response, one transaction at a time.
module upstream_risk_scheduler
    import upstream_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int CLIENT_W  = DEF_CLIENT_W,
    parameter int AMOUNT_W  = DEF_AMOUNT_W,
    localparam int PORT_W   = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS*CLIENT_W-1:0] req_client_id,
    input  logic [NUM_PORTS*AMOUNT_W-1:0] req_amount,
    input  logic [NUM_PORTS-1:0]          req_is_max,
    output logic [CLIENT_W-1:0]           ram_addr,
    output logic                          ram_rd_en,
    input  logic [AMOUNT_W-1:0]           ram_rd_accum,
    input  logic [AMOUNT_W-1:0]           ram_rd_max,
    input  logic [AMOUNT_W-1:0]           ram_rd_cancelled,
    output logic                          ram_wr_en,
    output logic                          ram_wr_sel_max,
    output logic [AMOUNT_W-1:0]           ram_wr_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [PORT_W-1:0]             rsp_port,
    output logic [CLIENT_W-1:0]           rsp_client_id,
    output logic                          rsp_accept
);

    state_t state, state_next;

    logic [NUM_PORTS-1:0] grant;
    logic [PORT_W-1:0]    grant_idx;
    logic                 grant_valid;
    logic                 advance;

    logic [CLIENT_W-1:0]  sel_client;
    logic [AMOUNT_W-1:0]  sel_amount;
    logic                 sel_is_max;

    logic [PORT_W-1:0]    port_q;
    logic [CLIENT_W-1:0]  client_q;
    logic [AMOUNT_W-1:0]  amount_q;
    logic                 is_max_q;
    logic                 accept_q;
    logic [AMOUNT_W-1:0]  wr_data_q;

    logic signed [AMOUNT_W+1:0] exposure;
    logic [AMOUNT_W+1:0]        exposure_pos;
    logic [AMOUNT_W:0]          accum_sum;
    logic [AMOUNT_W-1:0]        accum_sat;
    logic                       order_accept;

    assign advance = (state == IDLE) && grant_valid && !reset;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .advance     (advance),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_client = '0;
        sel_amount = '0;
        sel_is_max = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == PORT_W'(p)) begin
                sel_client = req_client_id[p*CLIENT_W +: CLIENT_W];
                sel_amount = req_amount[p*AMOUNT_W +: AMOUNT_W];
                sel_is_max = req_is_max[p];
            end
        end
    end

    // Cancelled orders may exceed accum+amount; negative exposure clamps to zero.
    always_comb begin
        exposure     = $signed({2'b00, ram_rd_accum}) + $signed({2'b00, amount_q})
                     - $signed({2'b00, ram_rd_cancelled});
        exposure_pos = exposure[AMOUNT_W+1] ? '0 : exposure;
        order_accept = exposure_pos <= {2'b00, ram_rd_max};
        accum_sum    = {1'b0, ram_rd_accum} + {1'b0, amount_q};
        accum_sat    = accum_sum[AMOUNT_W] ? '1 : accum_sum[AMOUNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (advance) state_next = READ;
            READ:    state_next = CHECK;
            CHECK:   state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_q    <= '0;
            client_q  <= '0;
            amount_q  <= '0;
            is_max_q  <= 1'b0;
            accept_q  <= 1'b0;
            wr_data_q <= '0;
        end else begin
            if (advance) begin
                port_q   <= grant_idx;
                client_q <= sel_client;
                amount_q <= sel_amount;
                is_max_q <= sel_is_max;
            end
            if (state == CHECK) begin
                accept_q  <= is_max_q | order_accept;
                wr_data_q <= is_max_q ? amount_q : accum_sat;
            end
        end
    end

    always_comb begin
        req_ready      = '0;
        ram_addr       = '0;
        ram_rd_en      = 1'b0;
        ram_wr_en      = 1'b0;
        ram_wr_sel_max = 1'b0;
        ram_wr_data    = '0;
        rsp_valid      = 1'b0;
        rsp_port       = '0;
        rsp_client_id  = '0;
        rsp_accept     = 1'b0;
        case (state)
            IDLE: if (advance) req_ready = grant;
            READ: begin
                ram_addr  = client_q;
                ram_rd_en = 1'b1;
            end
            CHECK: ram_addr = client_q;
            WRITE: begin
                ram_addr       = client_q;
                ram_wr_en      = accept_q;
                ram_wr_sel_max = accept_q & is_max_q;
                ram_wr_data    = accept_q ? wr_data_q : '0;
            end
            RESP: begin
                rsp_valid     = 1'b1;
                rsp_port      = port_q;
                rsp_client_id = client_q;
                rsp_accept    = accept_q;
            end
            default: ;
        endcase
    end

endmodule
